// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: gates the note-divider tone onto the buzzer pin as a
// fixed pattern of BEEPS bursts (ON_CYCLES audible, OFF_CYCLES silent).
// Optional feature macro: BUZZER_RETRIGGER_EN. When it is defined, a start
// during a sequence restarts the pattern from the first beep.
//
// Control semantics: start is a single-cycle request. It is accepted in IDLE,
// and also while busy when retrigger is enabled. stop is a level abort that
// returns to IDLE on the next edge and takes priority over start. done pulses
// for one cycle only when the final silence completes normally.
module buzzer_sequencer #(
  parameter int unsigned BEEPS      = 3,
  parameter logic [27:0] ON_CYCLES  = 28'd25_000_000,
  parameter logic [27:0] OFF_CYCLES = 28'd12_500_000
) (
  input  logic       clock_in,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       tone_in,
  output logic       buzzer_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  localparam logic [27:0] ON_LAST   = ON_CYCLES - 28'd1;
  localparam logic [27:0] OFF_LAST  = OFF_CYCLES - 28'd1;
  localparam logic [3:0]  BEEP_LAST = 4'(BEEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] phase_q, phase_d;
  logic [3:0]  beep_q, beep_d;
  logic        done_d;
  logic        buzzer_d;
  logic        retrig;

`ifdef BUZZER_RETRIGGER_EN
  // A start arriving mid-sequence restarts the pattern.
  assign retrig = start && (state_q != ST_IDLE);
`else
  // Mid-sequence starts are dropped.
  assign retrig = 1'b0;
`endif

  // Next-state logic: stop dominates, then retrigger, then normal phase stepping.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    beep_d  = beep_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      phase_d = 28'd0;
      beep_d  = 4'd0;
    end else if (retrig) begin
      state_d = ST_ON;
      phase_d = 28'd0;
      beep_d  = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ON;
            phase_d = 28'd0;
            beep_d  = 4'd0;
          end
        end
        ST_ON: begin
          if (phase_q == ON_LAST) begin
            state_d = ST_OFF;
            phase_d = 28'd0;
          end else begin
            phase_d = phase_q + 28'd1;
          end
        end
        ST_OFF: begin
          if (phase_q == OFF_LAST) begin
            phase_d = 28'd0;
            if (beep_q == BEEP_LAST) begin
              state_d = ST_IDLE;
              beep_d  = 4'd0;
              done_d  = 1'b1;
            end else begin
              state_d = ST_ON;
              beep_d  = beep_q + 4'd1;
            end
          end else begin
            phase_d = phase_q + 28'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          phase_d = 28'd0;
          beep_d  = 4'd0;
        end
      endcase
    end
  end

  // Tone passes only during the audible phase; it is registered once more on the way out.
  assign buzzer_d = (state_q == ST_ON) & tone_in;

  // State, counters and registered outputs; reset silences the buzzer immediately.
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= 28'd0;
      beep_q     <= 4'd0;
      buzzer_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      beep_q     <= beep_d;
      buzzer_out <= buzzer_d;
      done       <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// tb_buzzer_sequencer: directed tables, hand-written corner sequences and a
// randomized run against a timeline model of the beep pattern.
module tb_buzzer_sequencer;

  localparam int T_ON   = 4;
  localparam int T_OFF  = 3;
  localparam int T_BEEP = 3;
  localparam int T_LEN  = T_BEEP * (T_ON + T_OFF);
`ifdef BUZZER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  // clock / reset
  logic clock_in = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clock_in = ~clock_in;

  logic start = 1'b0, stop = 1'b0, tone_in = 1'b0;
  logic buzzer_out, busy, done;
  logic [1:0] state_dbg;

  logic start_e = 1'b0, stop_e = 1'b0, tone_e = 1'b0;
  logic buzzer_e, busy_e, done_e;
  logic [1:0] state_dbg_e;

  buzzer_sequencer #(.BEEPS(3), .ON_CYCLES(28'd4), .OFF_CYCLES(28'd3)) dut (
    .clock_in(clock_in), .rst_n(rst_n), .start(start), .stop(stop),
    .tone_in(tone_in), .buzzer_out(buzzer_out), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  buzzer_sequencer #(.BEEPS(1), .ON_CYCLES(28'd1), .OFF_CYCLES(28'd1)) dut_e (
    .clock_in(clock_in), .rst_n(rst_n), .start(start_e), .stop(stop_e),
    .tone_in(tone_e), .buzzer_out(buzzer_e), .busy(busy_e), .done(done_e),
    .state_dbg(state_dbg_e)
  );

  typedef struct {
    logic start;
    logic stop;
    logic tone;
    logic e_busy;
    logic e_buzz;
    logic e_done;
  } vec_t;

  vec_t vecs[26];
  int errors = 0;
  int checks = 0;

  // scoreboard
  task automatic chk(input string name, input int cyc, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  function automatic bit in_r(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  function automatic bit norm_buzz(input int c);
    return in_r(c, 2, 5) || in_r(c, 9, 12) || in_r(c, 16, 19);
  endfunction

  task automatic next_cycle;
    @(posedge clock_in);
    #1;
  endtask

  // Called 1 time unit after an edge; leaves the bench at the start of cycle 0.
  task automatic do_reset;
    start = 0; stop = 0; tone_in = 0;
    start_e = 0; stop_e = 0; tone_e = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_busy", 0, busy, 1'b0);
    chk("reset_buzz", 0, buzzer_out, 1'b0);
    chk("reset_done", 0, done, 1'b0);
    @(posedge clock_in);
    @(posedge clock_in);
    #4 rst_n = 1'b1;
    next_cycle();
  endtask

  // Apply the directed vector table, checking mid-cycle.
  task automatic run_table(input string tag);
    for (int c = 0; c < 26; c++) begin
      start = vecs[c].start; stop = vecs[c].stop; tone_in = vecs[c].tone;
      #3;
      chk({tag, "_busy"}, c, busy, vecs[c].e_busy);
      chk({tag, "_buzz"}, c, buzzer_out, vecs[c].e_buzz);
      chk({tag, "_done"}, c, done, vecs[c].e_done);
      next_cycle();
    end
    start = 0; stop = 0;
  endtask

  // timeline reference model
  bit   m_active;
  int   m_el;
  logic m_buzz, m_done;

  initial begin
    logic prev_tone;
    logic on_now;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_tone;
    logic on_now;
    for (int c = 0; c < 26; c++) begin
      vecs[c].start  = (c == 0);
      vecs[c].stop   = 1'b0;
      vecs[c].tone   = 1'b1;
      vecs[c].e_busy = in_r(c, 1, 21);
      vecs[c].e_buzz = norm_buzz(c);
      vecs[c].e_done = (c == 22);
    end
    #1;

    // Normal sequence
    do_reset();
    run_table("normal");

    // Back-to-back: start in the done cycle is accepted
    do_reset();
    for (int c = 0; c < 26; c++) begin
      start = (c == 0) || (c == 22); tone_in = 1'b1;
      #3;
      chk("b2b_busy", c, busy, in_r(c, 1, 21) || (c >= 23));
      chk("b2b_buzz", c, buzzer_out, norm_buzz(c) || in_r(c, 24, 27));
      chk("b2b_done", c, done, c == 22);
      next_cycle();
    end
    start = 0;

    // Tone gating
    do_reset();
    prev_tone = 1'b0;
    for (int c = 0; c < 26; c++) begin
      start = (c == 0); tone_in = (c % 2 == 0);
      #3;
      chk("gate_buzz", c, buzzer_out, norm_buzz(c) && prev_tone);
      chk("gate_busy", c, busy, in_r(c, 1, 21));
      prev_tone = tone_in;
      next_cycle();
    end
    start = 0;

    // Abort at cycle 10
    do_reset();
    for (int c = 0; c < 26; c++) begin
      start = (c == 0); stop = (c == 10); tone_in = 1'b1;
      #3;
      chk("abort_busy", c, busy, in_r(c, 1, 10));
      chk("abort_buzz", c, buzzer_out, in_r(c, 2, 5) || in_r(c, 9, 11));
      chk("abort_done", c, done, 1'b0);
      next_cycle();
    end
    start = 1; stop = 1;
    next_cycle();
    start = 0; stop = 0;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("startstop_busy", c, busy, 1'b0);
      chk("startstop_buzz", c, buzzer_out, 1'b0);
      next_cycle();
    end

    // Reset mid-operation at cycle 9.5
    do_reset();
    for (int c = 0; c < 10; c++) begin
      start = (c == 0); tone_in = 1'b1;
      #3;
      chk("prerst_busy", c, busy, in_r(c, 1, 21));
      chk("prerst_buzz", c, buzzer_out, norm_buzz(c));
      if (c < 9) next_cycle();
    end
    start = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 9, busy, 1'b0);
    chk("midrst_buzz", 9, buzzer_out, 1'b0);
    chk("midrst_done", 9, done, 1'b0);
    @(posedge clock_in);
    @(posedge clock_in);
    #4 rst_n = 1'b1;
    next_cycle();
    run_table("after_rst");

    // Second start at cycle 6
    do_reset();
    for (int c = 0; c < 32; c++) begin
      start = (c == 0) || (c == 6); tone_in = 1'b1;
      #3;
      if (RETRIG) begin
        chk("busystart_busy", c, busy, in_r(c, 1, 27));
        chk("busystart_buzz", c, buzzer_out,
            in_r(c, 2, 5) || in_r(c, 8, 11) || in_r(c, 15, 18) || in_r(c, 22, 25));
        chk("busystart_done", c, done, c == 28);
      end else begin
        chk("busystart_busy", c, busy, in_r(c, 1, 21));
        chk("busystart_buzz", c, buzzer_out, norm_buzz(c));
        chk("busystart_done", c, done, c == 22);
      end
      next_cycle();
    end
    start = 0;

    // Minimal parameters
    do_reset();
    for (int c = 0; c < 6; c++) begin
      start_e = (c == 0); tone_e = 1'b1;
      #3;
      chk("edge_busy", c, busy_e, in_r(c, 1, 2));
      chk("edge_buzz", c, buzzer_e, c == 2);
      chk("edge_done", c, done_e, c == 3);
      next_cycle();
    end
    start_e = 0;

    // Randomized run against the timeline model
    do_reset();
    m_active = 1'b0; m_el = 0; m_buzz = 1'b0; m_done = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 39) == 0);
      tone_in = $urandom_range(0, 1) == 1;
      #3;
      chk("rnd_busy", c, busy, m_active);
      chk("rnd_buzz", c, buzzer_out, m_buzz);
      chk("rnd_done", c, done, m_done);
      on_now = m_active && ((m_el % (T_ON + T_OFF)) < T_ON);
      m_buzz = on_now & tone_in;
      if (stop) begin
        m_active = 1'b0; m_done = 1'b0;
      end else if (start && (!m_active || RETRIG)) begin
        m_active = 1'b1; m_el = 0; m_done = 1'b0;
      end else if (m_active) begin
        if (m_el == T_LEN - 1) begin
          m_active = 1'b0; m_done = 1'b1;
        end else begin
          m_el++; m_done = 1'b0;
        end
      end else begin
        m_done = 1'b0;
      end
      next_cycle();
    end
    start = 0; stop = 0;

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
